// File: rtl/spu_branch_pkg.sv
// Shared branch-path types: redirect controller state and the default PC width
// used by the Branch unit, fetch and the redirect controller.
package spu_branch_pkg;

    localparam int PC_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        DRAIN    = 2'd2
    } redirect_state_e;

endpackage

// File: rtl/branch_redirect_ctrl_if.sv
// Branch-result / fetch-redirect / issue-control bundle around the redirect controller.
interface branch_redirect_ctrl_if
    import spu_branch_pkg::*;
#(
    parameter int PC_WIDTH = PC_WIDTH_DEF
) ();
    logic                br_valid;
    logic                br_taken;
    logic [PC_WIDTH-1:0] br_target;
    logic                br_initial;
    logic                fetch_ready;
    logic                redirect_valid;
    logic [PC_WIDTH-1:0] redirect_pc;
    logic                squash;
    logic                kill_twin;
    logic                stall_issue;
    logic                busy;
    logic [15:0]         taken_count;

    // master: branch unit / fetch / issue side driving the controller
    modport master (
        output br_valid, br_taken, br_target, br_initial, fetch_ready,
        input  redirect_valid, redirect_pc, squash, kill_twin, stall_issue, busy, taken_count
    );

    modport slave (
        input  br_valid, br_taken, br_target, br_initial, fetch_ready,
        output redirect_valid, redirect_pc, squash, kill_twin, stall_issue, busy, taken_count
    );
endinterface

// File: rtl/branch_sat_counter.sv
// Parameterised-width saturating up-counter with asynchronous active-high reset.
module branch_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);
    logic [WIDTH-1:0] r_count;
    logic             w_sat;

    assign w_sat   = &r_count;
    assign o_count = r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_count <= '0;
        else if (i_inc && !w_sat)
            r_count <= r_count + 1'b1;
    end
endmodule

// File: rtl/branch_redirect_ctrl.sv
// Redirects fetch after a taken branch, squashes wrong-path work and stalls issue
// until the younger stages have drained.
module branch_redirect_ctrl
    import spu_branch_pkg::*;
#(
    parameter int PC_WIDTH    = PC_WIDTH_DEF,
    parameter int FLUSH_DEPTH = 3
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    branch_redirect_ctrl_if.slave bus
);
    localparam logic [3:0] DRAIN_LOAD = 4'(FLUSH_DEPTH - 1);

    redirect_state_e     r_state, w_state_nxt;
    logic [PC_WIDTH-1:0] r_pc;
    logic                r_initial;
    logic                r_first;
    logic [3:0]          r_drain, w_drain_nxt;
    logic                w_accept;

    // Only branches seen in IDLE are on the correct path.
    assign w_accept = (r_state == IDLE) && bus.br_valid && bus.br_taken;

    always_comb begin
        w_state_nxt = r_state;
        w_drain_nxt = r_drain;
        case (r_state)
            IDLE: begin
                if (w_accept)
                    w_state_nxt = REDIRECT;
            end
            REDIRECT: begin
                if (bus.fetch_ready) begin
                    w_state_nxt = DRAIN;
                    w_drain_nxt = DRAIN_LOAD;
                end
            end
            DRAIN: begin
                if (r_drain == 4'd0)
                    w_state_nxt = IDLE;
                else
                    w_drain_nxt = r_drain - 4'd1;
            end
            default: begin
                w_state_nxt = IDLE;
                w_drain_nxt = 4'd0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_drain   <= 4'd0;
            r_pc      <= '0;
            r_initial <= 1'b0;
            r_first   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_drain <= w_drain_nxt;
            r_first <= w_accept;
            if (w_accept) begin
                r_pc      <= bus.br_target;
                r_initial <= bus.br_initial;
            end
        end
    end

    // Outputs decode registered state only; no input-to-output path.
    assign bus.redirect_valid = (r_state == REDIRECT);
    assign bus.redirect_pc    = r_pc;
    assign bus.squash         = (r_state != IDLE);
    assign bus.stall_issue    = (r_state != IDLE);
    assign bus.busy           = (r_state != IDLE);
    assign bus.kill_twin      = (r_state == REDIRECT) && r_first && r_initial;

    branch_sat_counter #(.WIDTH(16)) u_cnt (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_inc   (w_accept),
        .o_count (bus.taken_count)
    );
endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Table-driven, scoreboarded bench for branch_redirect_ctrl (FLUSH_DEPTH=3).
module tb_branch_redirect_ctrl;
    import spu_branch_pkg::*;

    typedef struct {
        logic       v, t;
        logic [7:0] tgt;
        logic       ini, fr;
        logic [28:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    logic [28:0] sb_q[$];
    vec_t vecs[25];

    always #5 clk = ~clk;

    branch_redirect_ctrl_if #(.PC_WIDTH(8)) bus ();

    branch_redirect_ctrl #(.PC_WIDTH(8), .FLUSH_DEPTH(3)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    // {redirect_valid, redirect_pc, squash, kill_twin, stall_issue, busy, taken_count}
    function automatic logic [28:0] e(input logic rv, input logic [7:0] pc, input logic sq,
                                      input logic kt, input logic st, input logic by,
                                      input logic [15:0] c);
        return {rv, pc, sq, kt, st, by, c};
    endfunction
    function automatic logic [28:0] idl(input logic [7:0] pc, input logic [15:0] c);
        return e(1'b0, pc, 1'b0, 1'b0, 1'b0, 1'b0, c);
    endfunction
    function automatic logic [28:0] rdr(input logic [7:0] pc, input logic kt, input logic [15:0] c);
        return e(1'b1, pc, 1'b1, kt, 1'b1, 1'b1, c);
    endfunction
    function automatic logic [28:0] drn(input logic [7:0] pc, input logic [15:0] c);
        return e(1'b0, pc, 1'b1, 1'b0, 1'b1, 1'b1, c);
    endfunction

    function automatic logic [28:0] observe();
        return {bus.redirect_valid, bus.redirect_pc, bus.squash, bus.kill_twin,
                bus.stall_issue, bus.busy, bus.taken_count};
    endfunction

    task automatic check(input string name, input logic [28:0] req);
        logic [28:0] act;
        act = observe();
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got rv=%b pc=%h sq=%b kt=%b st=%b busy=%b cnt=%h, want rv=%b pc=%h sq=%b kt=%b st=%b busy=%b cnt=%h",
                     name, act[28], act[27:20], act[19], act[18], act[17], act[16], act[15:0],
                     req[28], req[27:20], req[19], req[18], req[17], req[16], req[15:0]);
        end
    endtask

    // Drive one cycle of inputs, expect the registered result after the edge.
    task automatic step(input string name, input vec_t v);
        logic [28:0] req;
        bus.br_valid    = v.v;
        bus.br_taken    = v.t;
        bus.br_target   = v.tgt;
        bus.br_initial  = v.ini;
        bus.fetch_ready = v.fr;
        sb_q.push_back(v.exp);
        @(posedge clk);
        @(negedge clk);
        req = sb_q.pop_front();
        check(name, req);
    endtask

    initial begin
        vec_t nv;
        bus.br_valid    = 1'b0;
        bus.br_taken    = 1'b0;
        bus.br_target   = 8'h00;
        bus.br_initial  = 1'b0;
        bus.fetch_ready = 1'b0;

        // not-taken, taken with ready, backpressure, wrong-path, back-to-back
        vecs[0]  = '{1'b1, 1'b0, 8'h20, 1'b0, 1'b0, idl(8'h00, 16'd0)};
        vecs[1]  = '{1'b1, 1'b1, 8'h2C, 1'b1, 1'b1, rdr(8'h2C, 1'b1, 16'd1)};
        vecs[2]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, drn(8'h2C, 16'd1)};
        vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, drn(8'h2C, 16'd1)};
        vecs[4]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, drn(8'h2C, 16'd1)};
        vecs[5]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, idl(8'h2C, 16'd1)};
        vecs[6]  = '{1'b1, 1'b1, 8'h2C, 1'b0, 1'b0, rdr(8'h2C, 1'b0, 16'd2)};
        for (int i = 7; i <= 11; i++)
            vecs[i] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, rdr(8'h2C, 1'b0, 16'd2)};
        vecs[12] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, drn(8'h2C, 16'd2)};
        vecs[13] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, drn(8'h2C, 16'd2)};
        vecs[14] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, drn(8'h2C, 16'd2)};
        vecs[15] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, idl(8'h2C, 16'd2)};
        vecs[16] = '{1'b1, 1'b1, 8'h2C, 1'b1, 1'b0, rdr(8'h2C, 1'b1, 16'd3)};
        vecs[17] = '{1'b1, 1'b1, 8'h40, 1'b1, 1'b0, rdr(8'h2C, 1'b0, 16'd3)};
        vecs[18] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, drn(8'h2C, 16'd3)};
        vecs[19] = '{1'b1, 1'b1, 8'h40, 1'b1, 1'b0, drn(8'h2C, 16'd3)};
        vecs[20] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, drn(8'h2C, 16'd3)};
        vecs[21] = '{1'b1, 1'b1, 8'h40, 1'b1, 1'b0, idl(8'h2C, 16'd3)};
        vecs[22] = '{1'b1, 1'b1, 8'h40, 1'b1, 1'b1, rdr(8'h40, 1'b1, 16'd4)};
        vecs[23] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, drn(8'h40, 16'd4)};
        vecs[24] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, drn(8'h40, 16'd4)};

        #6;
        rst = 1'b0;
        check("reset_state", idl(8'h00, 16'd0));

        for (int i = 0; i < 25; i++)
            step($sformatf("vec%0d", i), vecs[i]);

        // async reset in the middle of DRAIN: outputs must clear before any edge
        #2 rst = 1'b1;
        #1 check("reset_mid_drain", idl(8'h00, 16'd0));
        @(negedge clk);
        rst = 1'b0;
        nv = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, idl(8'h00, 16'd0)};
        step("no_replay0", nv);
        step("no_replay1", nv);

        // saturation: preload one below the ceiling
        force dut.u_cnt.r_count = 16'hFFFE;
        #1 release dut.u_cnt.r_count;
        check("preload", idl(8'h00, 16'hFFFE));
        step("sat_take0", '{1'b1, 1'b1, 8'h55, 1'b1, 1'b1, rdr(8'h55, 1'b1, 16'hFFFF)});
        for (int i = 0; i < 3; i++)
            step("sat_drain0", '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, drn(8'h55, 16'hFFFF)});
        step("sat_idle0", '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, idl(8'h55, 16'hFFFF)});
        step("sat_take1", '{1'b1, 1'b1, 8'h66, 1'b0, 1'b1, rdr(8'h66, 1'b0, 16'hFFFF)});
        for (int i = 0; i < 3; i++)
            step("sat_drain1", '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, drn(8'h66, 16'hFFFF)});
        step("sat_idle1", '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, idl(8'h66, 16'hFFFF)});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
